// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: one shift-add or restoring-divide
// step per cycle over a shared accumulator, with early-out for div-by-zero/overflow.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [XLEN-1:0]     opnd;   // multiplicand for MUL*, divisor for DIV*/REM*
    logic [2*XLEN-1:0]   acc;    // {hi, lo}: product, or {remainder, quotient}
    logic [CW-1:0]       cnt;

    logic                is_div, signed_a, signed_b, sa, sb;
    logic                div_zero, div_ovf, special, accept;
    logic [XLEN-1:0]     mag_a, mag_b, special_res;
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   step_nxt, prod;
    logic [XLEN-1:0]     div_word, fix_word;

    // Acceptance-time decode: operand signedness, magnitudes and early-out cases.
    always_comb begin
        is_div   = funct3[2];
        signed_a = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        signed_b = is_div ? ~funct3[0] : ~funct3[1];
        sa       = signed_a & op_a[XLEN-1];
        sb       = signed_b & op_b[XLEN-1];
        mag_a    = sa ? -op_a : op_a;
        mag_b    = sb ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special  = div_zero | div_ovf;
        if (div_zero) special_res = funct3[1] ? op_a : '1;
        else          special_res = funct3[1] ? '0 : op_a;
        accept   = (state == IDLE) && start && !flush;
    end

    // One iteration of the shared datapath.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift - {1'b0, opnd};
        if (op_q[2])
            step_nxt = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc[XLEN-2:0], div_ge};
        else
            step_nxt = {mul_sum, acc[XLEN-1:1]};
    end

    // Sign correction and output word select.
    always_comb begin
        prod     = neg_q ? -acc : acc;
        div_word = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (op_q[2])
            fix_word = neg_q ? -div_word : div_word;
        else
            fix_word = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next-state is assigned a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) state_nxt = special ? DONE : CALC;
                CALC: if (cnt == CW'(1)) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            op_q  <= funct3;
            neg_q <= (is_div && funct3[1]) ? sa : (sa ^ sb);
            opnd  <= is_div ? mag_b : mag_a;
            acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            cnt   <= CW'(XLEN);
            if (special) result <= special_res;
        end else if (!flush) begin
            if (state == CALC) begin
                acc <= step_nxt;
                cnt <= cnt - CW'(1);
            end else if (state == FIX) begin
                result <= fix_word;
            end
        end
    end

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, randomized ops
// against a 64-bit arithmetic reference model, flush and async reset scenarios.
module tb_muldiv_sequencer;

    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics via plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == MIN_INT && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_INT;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, measure latency and busy length, check result and done width.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit scribble);
        logic [31:0] exp;
        int          lat, nbusy, exp_lat;
        exp     = model(f3, a, b);
        exp_lat = is_special(f3, a, b) ? 1 : 34;
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        lat = 0; nbusy = 0;
        for (int k = 1; k <= 100; k++) begin
            #1;
            if (k == 1) start = 1'b0;
            if (done) begin lat = k; break; end
            if (busy) nbusy++;
            if (scribble && k >= 4 && k <= 12) begin
                start  = (k < 12);
                op_a   = $urandom;
                op_b   = $urandom;
                funct3 = 3'($urandom);
            end
            @(posedge clk);
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
        check({tag, " result"}, result, exp);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'b0, done}, 32'h0);
        check({tag, " result_held"}, result, exp);
    endtask

    initial begin
        logic [31:0] prev;
        bit          saw_done;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset result", result, 32'h0);
        @(negedge clk); rst = 1'b0;

        do_op("mul_neg",   3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        do_op("mulhu",     3'd3, 32'd7, 32'hFFFF_FFFD, 1'b0);
        do_op("mulh_min",  3'd1, MIN_INT, MIN_INT, 1'b0);
        do_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("divu",      3'd5, 32'd100, 32'd7, 1'b0);
        do_op("remu",      3'd7, 32'd100, 32'd7, 1'b0);
        do_op("divu_zero", 3'd5, 32'd5, 32'd0, 1'b0);
        do_op("remu_zero", 3'd7, 32'd5, 32'd0, 1'b0);
        do_op("div_ovf",   3'd4, MIN_INT, 32'hFFFF_FFFF, 1'b0);
        do_op("rem_ovf",   3'd6, MIN_INT, 32'hFFFF_FFFF, 1'b0);
        do_op("div_scrib", 3'd4, 32'd1000, 32'hFFFF_FFF6, 1'b1);

        // Flush in mid-CALC: abort, no done, result untouched.
        prev = result;
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        check("flush busy_before", {31'b0, busy}, 32'h1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy_after", {31'b0, busy}, 32'h0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("flush no_done", {31'b0, saw_done}, 32'h0);
        check("flush result_kept", result, prev);
        do_op("after_flush", 3'd0, 32'd123, 32'd456, 1'b0);

        // Flush wins over start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_prio busy", {31'b0, busy}, 32'h0);
        check("flush_prio done", {31'b0, done}, 32'h0);

        // Random ops against the model.
        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom);
            ra  = pick_operand();
            rb  = pick_operand();
            do_op($sformatf("rand%0d f3=%0d", i, rf3), rf3, ra, rb, (i % 5) == 0);
        end

        // Async reset mid-CALC.
        do_op("pre_reset", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        @(negedge clk);
        funct3 = 3'd2; op_a = 32'hDEAD_BEEF; op_b = 32'h0000_FFFF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_mid busy", {31'b0, busy}, 32'h0);
        check("rst_mid done", {31'b0, done}, 32'h0);
        check("rst_mid result", result, 32'h0);
        @(negedge clk); rst = 1'b0;
        do_op("after_reset", 3'd6, 32'hFFFF_FF9C, 32'd7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative sequencer for the RV32M multiply/divide instructions. It is started by the execute stage once the control decode identifies an M-extension op (opcode 0110011, funct7 0000001). It runs a shared 32-step shift-add / restoring-divide datapath and stalls the pipeline through busy until a one-cycle done pulse returns the result. Divide-by-zero and signed overflow take an early-out path.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN; counter width is clog2(XLEN)+1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (multiplicand / dividend)
op_b  input  XLEN  rs2 value (multiplier / divisor)
flush  input  1  pipeline kill; aborts any operation in progress
busy  output  1  high while an accepted op is in flight; pipeline stall
done  output  1  one-cycle pulse when result is valid
result  output  XLEN  registered result; held stable until the next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, all internal registers=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 latches funct3 and the operand magnitudes (absolute values for signed operands per op), plus the result sign.
  - Normal op: next state CALC, counter=XLEN. Special case: next state DONE.
- CALC: one iteration per cycle; counter decrements; at counter=1 go to FIX. Exactly XLEN cycles.
  - Multiply: 2*XLEN-bit accumulator, shift-add.
  - Divide: restoring, 1 quotient bit per cycle.
- FIX: apply sign correction (two's-complement negate when required); select the output word; go to DONE.
  - MUL: low word. MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Quotient sign = sign(a) xor sign(b). Remainder sign = sign(a).
- DONE: result registered, done=1 for exactly this cycle, busy=0; next state IDLE.
- busy=1 in CALC and FIX only.
- Latency:
  - Normal op: start accepted at edge T, done high during cycle T+XLEN+2 (34 for XLEN=32).
  - Special case: done high during cycle T+1.
- Special cases (decided in IDLE, no iteration):
  - Divide by zero (op_b=0): DIV/DIVU result all ones; REM/REMU result = op_a.
  - Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- start while busy or in DONE: ignored; no queueing. The requester must hold start until it observes busy or done.
- flush=1 in any state: next state IDLE, no done pulse, result unchanged.
  - flush has priority over start in the same cycle.
  - flush in DONE still lets that cycle's done stand; the next state is IDLE.
- Operands are sampled only at acceptance; later changes to op_a/op_b/funct3 have no effect.
- Arithmetic: MULHSU treats op_a signed and op_b unsigned. All results are truncated to XLEN bits.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> busy high 33 cycles, done in cycle 34, result=0xFFFFFFEB; MULHU of the same operands -> 0x00000006.
- MULH op_a=op_b=0x80000000 -> result=0x40000000; MULHSU op_a=0xFFFFFFFF, op_b=2 -> 0xFFFFFFFF.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU op_a=5, op_b=0 -> done in cycle 1, result=0xFFFFFFFF; REMU -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1; REM -> 0.
- Start MUL, assert flush at cycle 10 -> busy=0 next cycle, no done, result keeps its prior value; an immediate new start is accepted and completes normally.
- Toggle start and change operands during CALC -> ignored, result matches the first op. Assert rst mid-CALC -> busy, done and result go to 0 immediately.
